// File: rtl/down_timer_pkg.sv
// down_timer_pkg: shared state type and default sizing for the down_timer block
package down_timer_pkg;
   localparam int DEF_WIDTH       = 6;
   localparam int DEF_SYNC_STAGES = 2;
   typedef enum logic [1:0] {IDLE, RUN, EXPIRED} timer_state_t;
endpackage

// File: rtl/down_timer_if.sv
// down_timer_if: control/status bundle for down_timer
//   enable : decrement qualifier
//   load   : load data as new interval (wins over enable)
//   data   : interval value
//   count  : remaining count (registered)
//   busy   : high while running
//   zero   : count == 0 (combinational)
//   done   : one-cycle expiry pulse
import down_timer_pkg::*;
interface down_timer_if #(parameter int WIDTH = DEF_WIDTH) ();
   logic             enable;
   logic             load;
   logic [WIDTH-1:0] data;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             zero;
   logic             done;
   modport master (output enable, load, data, input count, busy, zero, done);
   modport slave  (input enable, load, data, output count, busy, zero, done);
endinterface

// File: rtl/down_timer_aasd.sv
// aasd: asynchronous-assert, synchronous-deassert reset synchronizer
//   i_clk : clock
//   i_rst : raw asynchronous active-high reset
//   o_rst : internal reset, asserts at once, releases after SYNC_STAGES edges
import down_timer_pkg::*;
module aasd #(parameter int SYNC_STAGES = DEF_SYNC_STAGES) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_rst
);
   logic [SYNC_STAGES-1:0] r_sync;
   // zeros shift in from the bottom; the top flop drives the internal reset
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) r_sync <= '1;
      else       r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b0};
   assign o_rst = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/down_timer.sv
// down_timer: loadable down-counting interval timer with Done pulse and Busy/Zero status
//   i_clk : rising-edge clock
//   i_rst : asynchronous active-high reset (released through aasd)
//   bus   : down_timer_if.slave (enable, load, data in; count, busy, zero, done out)
// Optional build macro AUTO_RELOAD_EN: reload the last interval on expiry instead of stopping.
import down_timer_pkg::*;
module down_timer #(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic         i_clk,
   input  logic         i_rst,
   down_timer_if.slave  bus
);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   logic             w_rst;
   logic [WIDTH-1:0] r_count;
   timer_state_t     r_state;
   logic             r_busy;
   logic             r_done;
   aasd #(.SYNC_STAGES(SYNC_STAGES)) u_aasd (.i_clk(i_clk), .i_rst(i_rst), .o_rst(w_rst));
`ifdef AUTO_RELOAD_EN
   logic [WIDTH-1:0] r_reload;
   always_ff @(posedge i_clk or posedge w_rst)
      if (w_rst)          r_reload <= '0;
      else if (bus.load)  r_reload <= bus.data;
`endif
   // RUN only ever holds a nonzero count, so the decrement never underflows
   always_ff @(posedge i_clk or posedge w_rst)
      if (w_rst) begin
         r_count <= '0;
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (bus.load) begin
            r_count <= bus.data;
            r_state <= (bus.data != '0) ? RUN : IDLE;
            r_busy  <= (bus.data != '0);
         end else if (r_state == RUN && bus.enable) begin
            if (r_count == ONE) begin
               r_done <= 1'b1;
`ifdef AUTO_RELOAD_EN
               r_count <= r_reload;
`else
               r_count <= '0;
               r_state <= EXPIRED;
               r_busy  <= 1'b0;
`endif
            end else begin
               r_count <= r_count - ONE;
            end
         end
      end
   assign bus.count = r_count;
   assign bus.busy  = r_busy;
   assign bus.zero  = (r_count == '0);
   assign bus.done  = r_done;
endmodule

// File: doc/down_timer.md
# down_timer

Loadable down-counting interval timer; the decrementing counterpart to the team's loadable up-counter. Software or a controller loads a 6-bit interval, and the block counts it down on enabled cycles. It flags expiry with a one-cycle Done pulse and exposes Busy/Zero status. Reset passes through an AASD synchronizer so that assertion is immediate and release is clean.

## Interface
- WIDTH, 6, counter/data width in bits
- SYNC_STAGES, 2, flops in the AASD reset-release chain (minimum 2)

- Clock  input  1  rising-edge system clock
- Reset  input  1  asynchronous, active-high reset
- Enable  input  1  decrement qualifier, sampled on rising Clock
- Load  input  1  load Data as new interval; priority over Enable
- Data  input  WIDTH  interval value for Load
- Count  output  WIDTH  current remaining count (registered)
- Busy  output  1  high while in RUN (registered state decode)
- Zero  output  1  combinational, Count == 0
- Done  output  1  registered one-cycle expiry pulse

## Operation
- Internal reset `rst_i`:
  - Asserts asynchronously with Reset.
  - Deasserts after SYNC_STAGES rising Clock edges once Reset is low.
- Registers: Count, Reload (last loaded interval), state, Done.
- Reset values:
  - Count = 0, Reload = 0, state = IDLE.
  - Busy = 0, Done = 0, Zero = 1.
- States: IDLE, RUN, EXPIRED.
- Load = 1 (any state):
  - Count <= Data and Reload <= Data.
  - Done <= 0.
  - Next state is RUN if Data != 0, otherwise IDLE.
  - Enable is ignored in the same cycle.
- RUN, Enable = 1, Count > 1: Count <= Count − 1.
- RUN, Enable = 1, Count == 1:
  - Done <= 1.
  - Count <= 0, next state EXPIRED (AUTO_RELOAD_EN undefined).
- RUN, Enable = 0: all registers hold; Done <= 0.
- IDLE or EXPIRED: Enable has no effect; Count holds; Done <= 0.
- EXPIRED → RUN/IDLE only via Load.
- Arithmetic is unsigned, WIDTH bits. Underflow is impossible: decrement happens only when Count ≥ 1.
- Reset mid-count:
  - Outputs return to reset values immediately, without waiting for a clock edge.
  - Any Load or Enable during the release window is ignored.

## Timing
- Load sampled at edge N → Count = Data and Busy reflect it after edge N.
- Interval D loaded at edge N with Enable held high:
  - Done is high during the cycle after edge N+D.
  - Count = 0 in that same cycle.
- Done width is exactly one cycle per expiry.
- Zero follows Count combinationally, with no added latency.
- After Reset falls, the first effective Load is sampled on edge SYNC_STAGES+1.

## Configuration
- AUTO_RELOAD_EN defined:
  - At RUN, Enable = 1, Count == 1: Count <= Reload, Done <= 1, and the block stays in RUN.
  - This gives a periodic Done every Reload enabled cycles; EXPIRED is never entered.
  - With Reload = 1, Done is high on every enabled cycle.
- AUTO_RELOAD_EN undefined: one-shot behaviour as described in Operation.

## Structure
- Package `down_timer_pkg`:
  - `timer_state_t` enum (IDLE, RUN, EXPIRED).
  - Default WIDTH constant.
  - Default SYNC_STAGES constant.
- Sub-module `aasd`:
  - Parameterised SYNC_STAGES flop chain.
  - Inputs: Clock, Reset. Output: `rst_i`.
  - Reusable by other blocks.
- Top module contains the state register, the Count/Reload datapath and the Done flop.

## Test plan
- Reset release: Reset=1 for 2 cycles, then 0 → Count=0, Zero=1, Busy=0 during release; a Load of Data=5 at the first post-release edge is ignored; a Load of 5 at edge 3 takes effect.
- One-shot: Load Data=6'd7, Enable=1 → Count 7,6,…,1,0 on successive edges; Done=1 only in the Count=0 cycle; Busy drops; Count stays 0 for 5 further cycles.
- Enable gating and priority: Load 60, toggle Enable 1,0,1 → Count 60,59,59,58; then Load=1 with Enable=1 and Data=42 → Count=42, no decrement that cycle.
- Zero load and async reset: Load Data=0 → state IDLE, Zero=1, Done never pulses; then Load 10 and assert Reset mid-count at Count=4 between edges → Count=0 immediately, before the next edge.
- AUTO_RELOAD_EN build: Load 3, Enable=1 for 10 cycles → Count 3,2,1,3,2,1,… with Done high on each 1→3 transition; Load 1 → Done high on every enabled cycle.
- Load in EXPIRED: after expiry, Load 36 with Enable=0 → Count=36, Busy=1, Count holds 36 for 4 cycles.
